omr_sheet_loader: RTL

Upstream front end of the OMR grader. Accepts one scanned bubble row (4 option bits) per handshake and classifies each row as a single mark, blank or multi-mark. It assembles the 10 rows into the 40-bit student_answers vector with per-question blank and multi-mark masks. It then holds the completed sheet stable for the grader until acknowledged.

---
 rtl/omr_pkg.sv | 20 ++
 rtl/omr_sheet_loader_if.sv | 30 +++
 rtl/omr_row_classifier.sv | 20 ++
 rtl/omr_sheet_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/omr_pkg.sv
// Shared constants, FSM state type and slice helper for the OMR sheet front end.
package omr_pkg;

  localparam int NUM_Q  = 10;
  localparam int OPT_W  = 4;
  localparam int ANS_W  = NUM_Q * OPT_W;
  localparam int QIDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } omr_state_e;

  // MSB position of question q's slice: Q1 occupies the top nibble.
  function automatic int slice_pos(input int q);
    return ANS_W - 1 - OPT_W * q;
  endfunction

endpackage

// File: rtl/omr_sheet_loader_if.sv
// Scanner/grader facing signals of the sheet loader, bundled with loader and driver views.
// Handshake: a row transfers on any rising edge where row_valid && row_ready; the
// scanner holds row_data stable until then. The sheet is consumed on an edge where
// sheet_valid && sheet_ack.
interface omr_sheet_loader_if;
  import omr_pkg::*;

  logic                 sheet_start;
  logic                 row_valid;
  logic [OPT_W-1:0]     row_data;
  logic                 row_ready;
  logic [QIDX_W-1:0]    q_index;
  logic                 busy;
  logic [ANS_W-1:0]     student_answers;
  logic [NUM_Q-1:0]     blank_mask;
  logic [NUM_Q-1:0]     multi_mask;
  logic                 sheet_valid;
  logic                 sheet_ack;

  modport slave (
    input  sheet_start, row_valid, row_data, sheet_ack,
    output row_ready, q_index, busy, student_answers, blank_mask, multi_mask, sheet_valid
  );

  modport master (
    output sheet_start, row_valid, row_data, sheet_ack,
    input  row_ready, q_index, busy, student_answers, blank_mask, multi_mask, sheet_valid
  );

endinterface

// File: rtl/omr_row_classifier.sv
// Combinational classification of one bubble row into single mark, blank or multi-mark.
module omr_row_classifier
  import omr_pkg::*;
(
  input  logic [OPT_W-1:0] row_data,
  output logic             is_one_hot,
  output logic             is_blank,
  output logic             is_multi,
  output logic [OPT_W-1:0] row_clean
);

  always_comb begin
    is_one_hot = $onehot(row_data);
    is_blank   = (row_data == '0);
    is_multi   = !is_one_hot && !is_blank;
    // Anything other than a single mark is stored as 0000 so it never matches a key.
    row_clean  = is_one_hot ? row_data : '0;
  end

endmodule

// File: rtl/omr_sheet_loader.sv
// Assembles NUM_Q scanned rows into one answer vector with blank/multi masks and
// holds the completed sheet until the grader acknowledges it.
module omr_sheet_loader
  import omr_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  omr_sheet_loader_if.slave   bus,
  output omr_state_e          state_dbg
);

  omr_state_e          state_q, state_d;
  logic [QIDX_W-1:0]   q_index_q, q_index_d;
  logic [ANS_W-1:0]    answers_q, answers_d;
  logic [NUM_Q-1:0]    blank_q, blank_d;
  logic [NUM_Q-1:0]    multi_q, multi_d;

  logic                is_one_hot;
  logic                is_blank;
  logic                is_multi;
  logic [OPT_W-1:0]    row_clean;

  omr_row_classifier u_row_classifier (
    .row_data   (bus.row_data),
    .is_one_hot (is_one_hot),
    .is_blank   (is_blank),
    .is_multi   (is_multi),
    .row_clean  (row_clean)
  );

  always_comb begin
    state_d   = state_q;
    q_index_d = q_index_q;
    answers_d = answers_q;
    blank_d   = blank_q;
    multi_d   = multi_q;

    unique case (state_q)
      IDLE: begin
        if (bus.sheet_start) begin
          state_d   = LOAD;
          q_index_d = '0;
          answers_d = '0;
          blank_d   = '0;
          multi_d   = '0;
        end
      end

      LOAD: begin
        // A restart wins over a row presented in the same cycle.
        if (bus.sheet_start) begin
          q_index_d = '0;
          answers_d = '0;
          blank_d   = '0;
          multi_d   = '0;
        end else if (bus.row_valid) begin
          for (int i = 0; i < NUM_Q; i++) begin
            if (q_index_q == QIDX_W'(i)) begin
              answers_d[slice_pos(i) -: OPT_W] = is_one_hot ? row_clean : '0;
              blank_d[NUM_Q-1-i]               = is_blank;
              multi_d[NUM_Q-1-i]               = is_multi;
            end
          end
          if (q_index_q == QIDX_W'(NUM_Q - 1)) begin
            state_d   = HOLD;
            q_index_d = '0;
          end else begin
            q_index_d = q_index_q + QIDX_W'(1);
          end
        end
      end

      HOLD: begin
        if (bus.sheet_ack) begin
          if (bus.sheet_start) begin
            state_d   = LOAD;
            q_index_d = '0;
            answers_d = '0;
            blank_d   = '0;
            multi_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      q_index_q <= '0;
      answers_q <= '0;
      blank_q   <= '0;
      multi_q   <= '0;
    end else begin
      state_q   <= state_d;
      q_index_q <= q_index_d;
      answers_q <= answers_d;
      blank_q   <= blank_d;
      multi_q   <= multi_d;
    end
  end

  assign bus.row_ready       = (state_q == LOAD);
  assign bus.busy            = (state_q != IDLE);
  assign bus.sheet_valid     = (state_q == HOLD);
  assign bus.q_index         = q_index_q;
  assign bus.student_answers = answers_q;
  assign bus.blank_mask      = blank_q;
  assign bus.multi_mask      = multi_q;
  assign state_dbg           = state_q;

endmodule
